// File: rtl/ucaspian_pkg.sv
// Shared types and constants for the uCaspian synapse walker.
// Widths, config byte codes, RAM word layout and walker states.
package ucaspian_pkg;

    localparam int SYN_AW = 12;
    localparam int NRN_AW = 8;
    localparam int WGT_W  = 8;

    typedef struct packed {
        logic [WGT_W-1:0]  weight;
        logic [NRN_AW-1:0] target;
    } syn_word_t;

    localparam logic [2:0] CFG_ZERO   = 3'd1;
    localparam logic [2:0] CFG_WEIGHT = 3'd2;
    localparam logic [2:0] CFG_COMMIT = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WALK,
        ST_CLEAR
    } walk_state_t;

endpackage

// File: rtl/ucaspian_skid_buf.sv
// Two-entry valid/ready buffer with registered storage and flush.
// Upstream only pushes when it has reserved a free slot.
module ucaspian_skid_buf
    import ucaspian_pkg::*;
#(
    parameter int W = NRN_AW + WGT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic [W-1:0] in_data,
    input  logic         in_vld,
    output logic [W-1:0] out_data,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic         push;
    logic         pop;

    assign out_vld  = cnt != 2'd0;
    assign out_data = mem[rd_ptr];
    assign count    = cnt;
    assign push     = in_vld;
    assign pop      = out_vld && out_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/ucaspian_syn_walker.sv
// Walks inclusive synapse ranges, reads synapse RAM, streams dendrite beats.
// Optional UCASPIAN_SYN_SKIP_ZERO_EN drops zero-weight words at skid entry.
module ucaspian_syn_walker
    import ucaspian_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear_config,
    output logic              clear_done,
    input  logic [SYN_AW-1:0] config_addr,
    input  logic [7:0]        config_value,
    input  logic [2:0]        config_byte,
    input  logic              config_enable,
    input  logic              next_step,
    output logic              step_done,
    input  logic [SYN_AW-1:0] syn_start,
    input  logic [SYN_AW-1:0] syn_end,
    input  logic              syn_vld,
    output logic              syn_rdy,
    output logic [NRN_AW-1:0] dend_addr,
    output logic [WGT_W-1:0]  dend_weight,
    output logic              dend_vld,
    input  logic              dend_rdy
);

    walk_state_t       state_q;
    walk_state_t       state_d;
    logic [SYN_AW-1:0] cur_q;
    logic [SYN_AW-1:0] end_q;
    logic [SYN_AW-1:0] clr_addr_q;
    logic              clr_done_q;
    logic              rd_vld_q;
    logic              step_done_q;
    syn_word_t         shadow_q;
    syn_word_t         ram_q;
    syn_word_t         wr_word;
    syn_word_t         skid_out;
    syn_word_t         ram [0:(1<<SYN_AW)-1];
    logic [1:0]        skid_cnt;
    logic [2:0]        occ;
    logic [2:0]        lim;
    logic              accept;
    logic              pop;
    logic              space;
    logic              rd_en;
    logic              clr_we;
    logic              cfg_ok;
    logic              cfg_we;
    logic              push;
    logic              flush;
    logic              unused;

    assign unused = next_step;

    assign syn_rdy = reset && state_q == ST_IDLE
                   && enable && !clear_config;
    assign accept  = syn_vld && syn_rdy;
    assign pop     = dend_vld && dend_rdy;

    // Count in-flight reads against skid slots so no beat is ever dropped.
    assign occ   = {1'b0, skid_cnt} + {2'b00, rd_vld_q};
    assign lim   = pop ? 3'd2 : 3'd1;
    assign space = occ <= lim;
    assign rd_en = state_q == ST_WALK && enable
                 && space && !clear_config;

    assign clr_we = state_q == ST_CLEAR && !clr_done_q;
    assign cfg_ok = state_q == ST_IDLE && !clear_config
                  && config_enable;
    assign cfg_we = cfg_ok && config_byte == CFG_COMMIT;
    assign wr_word.weight = shadow_q.weight;
    assign wr_word.target = config_value;

    assign flush = clear_config || state_q == ST_CLEAR;
`ifdef UCASPIAN_SYN_SKIP_ZERO_EN
    assign push = rd_vld_q && (ram_q.weight != '0);
`else
    assign push = rd_vld_q;
`endif

    always_comb begin
        state_d = state_q;
        if (clear_config) begin
            state_d = ST_CLEAR;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (accept) state_d = ST_WALK;
                ST_WALK:  if (rd_en && cur_q == end_q) state_d = ST_IDLE;
                ST_CLEAR: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            end_q       <= '0;
            clr_addr_q  <= '0;
            clr_done_q  <= 1'b0;
            rd_vld_q    <= 1'b0;
            step_done_q <= 1'b0;
            shadow_q    <= '0;
        end else begin
            state_q  <= state_d;
            rd_vld_q <= rd_en;
            if (accept) begin
                cur_q <= syn_start;
                end_q <= syn_end;
            end else if (rd_en) begin
                cur_q <= cur_q + SYN_AW'(1);
            end
            if (state_q != ST_CLEAR || !clear_config) begin
                clr_addr_q <= '0;
                clr_done_q <= 1'b0;
            end else if (clr_we) begin
                clr_addr_q <= clr_addr_q + SYN_AW'(1);
                if (&clr_addr_q) clr_done_q <= 1'b1;
            end
            if (cfg_ok) begin
                unique case (1'b1)
                    (config_byte == CFG_ZERO):   shadow_q <= '0;
                    (config_byte == CFG_WEIGHT): shadow_q.weight <= config_value;
                    (config_byte == CFG_COMMIT): shadow_q.target <= config_value;
                    default: ;
                endcase
            end
            step_done_q <= state_q == ST_IDLE && !syn_vld && !rd_vld_q
                         && skid_cnt == 2'd0 && !dend_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            ram[clr_addr_q] <= '0;
        end else if (cfg_we) begin
            ram[config_addr] <= wr_word;
        end
        if (rd_en) begin
            ram_q <= ram[cur_q];
        end
    end

    ucaspian_skid_buf #(
        .W(NRN_AW + WGT_W)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .in_data (ram_q),
        .in_vld  (push),
        .out_data(skid_out),
        .out_vld (dend_vld),
        .out_rdy (dend_rdy),
        .count   (skid_cnt)
    );

    assign dend_addr   = skid_out.target;
    assign dend_weight = skid_out.weight;
    assign clear_done  = clr_done_q;
    assign step_done   = step_done_q;

endmodule
